// File: rtl/i2c_pkg.sv
// i2c_pkg: encodings and widths shared by i2c_target and i2c_controller.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [7:0] ST_IDLE      = 8'b0000_0001;
  localparam logic [7:0] ST_ADDR      = 8'b0000_0010;
  localparam logic [7:0] ST_ADDR_ACK  = 8'b0000_0100;
  localparam logic [7:0] ST_WRITE     = 8'b0000_1000;
  localparam logic [7:0] ST_WRITE_ACK = 8'b0001_0000;
  localparam logic [7:0] ST_READ      = 8'b0010_0000;
  localparam logic [7:0] ST_READ_ACK  = 8'b0100_0000;
  localparam logic [7:0] ST_IGNORE    = 8'b1000_0000;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } i2c_line_t;

endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: byte-stream side of i2c_target (RX frames, TX request/response, busy).
interface i2c_target_if;
  import i2c_pkg::*;

  logic                  rx_begin_o;
  logic [I2C_BYTE_W-1:0] rx_byte_o;
  logic                  rx_byte_valid_o;
  logic                  rx_end_o;
  logic                  tx_byte_req_o;
  logic [I2C_BYTE_W-1:0] tx_byte_i;
  logic                  busy_o;

  modport master (
    output rx_begin_o, rx_byte_o, rx_byte_valid_o, rx_end_o, tx_byte_req_o, busy_o,
    input  tx_byte_i
  );

  modport slave (
    input  rx_begin_o, rx_byte_o, rx_byte_valid_o, rx_end_o, tx_byte_req_o, busy_o,
    output tx_byte_i
  );

endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: async line synchronizer, optional glitch filter, rise/fall detect.
// Build macro I2C_TARGET_GLITCH_FILTER_EN enables the C_FILTER_LEN-cycle stable filter.
module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int C_SYNC_STAGES = 2,
  parameter int C_FILTER_LEN  = 3
) (
  input  logic      clk,
  input  logic      raw,
  output i2c_line_t line
);

  if (C_SYNC_STAGES < 2 || C_FILTER_LEN < 2) begin : g_cfg_err
    $error("i2c_line_sync: C_SYNC_STAGES and C_FILTER_LEN must be >= 2");
  end

  // No reset here: the FSM reset alone suffices, and never forcing the line
  // value avoids a false START/STOP edge when reset releases mid-transfer.
  logic [C_SYNC_STAGES-1:0] sync;
  logic                     clean;
  logic                     prev;

  always_ff @(posedge clk) begin
    sync <= {sync[C_SYNC_STAGES-2:0], raw};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [C_FILTER_LEN-1:0] hist;

  always_ff @(posedge clk) begin
    hist <= {hist[C_FILTER_LEN-2:0], sync[C_SYNC_STAGES-1]};
    if (&hist) begin
      clean <= 1'b1;
    end else if (~|hist) begin
      clean <= 1'b0;
    end
  end
`else
  assign clean = sync[C_SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    prev <= clean;
  end

  assign line.lvl  = clean;
  assign line.rise = clean & ~prev;
  assign line.fall = ~clean & prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder, 7-bit address; writes become begin/byte/end frames, reads pull bytes on request.
// Build macro I2C_TARGET_GLITCH_FILTER_EN adds a glitch filter on SCL/SDA (see i2c_line_sync).
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] C_TARGET_ADDR = 7'h50,
  parameter int                    C_SYNC_STAGES = 2,
  parameter int                    C_FILTER_LEN  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         I2C_SCL_I,
  input  logic         I2C_SDA_I,
  output logic         I2C_SDA_O,
  output logic         I2C_SDA_OE,
  i2c_target_if.master bus
);

  i2c_line_t scl;
  i2c_line_t sda;

  i2c_line_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_FILTER_LEN(C_FILTER_LEN)) u_scl_sync (
    .clk  (clk),
    .raw  (I2C_SCL_I),
    .line (scl)
  );

  i2c_line_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_FILTER_LEN(C_FILTER_LEN)) u_sda_sync (
    .clk  (clk),
    .raw  (I2C_SDA_I),
    .line (sda)
  );

  logic start_evt;
  logic stop_evt;
  assign start_evt = sda.fall & scl.lvl;
  assign stop_evt  = sda.rise & scl.lvl;

  logic [7:0]            state;
  logic [3:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shift;
  logic [I2C_BYTE_W-1:0] tx_shift;
  logic                  sda_oe;
  logic                  rx_active;
  logic                  rw;
  logic                  req_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      bit_cnt             <= 4'd0;
      shift               <= '0;
      sda_oe              <= 1'b0;
      rx_active           <= 1'b0;
      rw                  <= I2C_RW_WRITE;
      req_d               <= 1'b0;
      bus.rx_begin_o      <= 1'b0;
      bus.rx_byte_o       <= '0;
      bus.rx_byte_valid_o <= 1'b0;
      bus.rx_end_o        <= 1'b0;
      bus.tx_byte_req_o   <= 1'b0;
      bus.busy_o          <= 1'b0;
    end else begin
      bus.rx_begin_o      <= 1'b0;
      bus.rx_byte_valid_o <= 1'b0;
      bus.rx_end_o        <= 1'b0;
      bus.tx_byte_req_o   <= 1'b0;
      // Read byte is taken two clocks after the request pulse was raised.
      req_d <= bus.tx_byte_req_o;
      if (req_d) begin
        tx_shift <= bus.tx_byte_i;
      end

      if (start_evt || stop_evt) begin
        state        <= start_evt ? ST_ADDR : ST_IDLE;
        bus.busy_o   <= start_evt;
        sda_oe       <= 1'b0;
        bit_cnt      <= 4'd0;
        bus.rx_end_o <= rx_active;
        rx_active    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl.rise) begin
              shift <= {shift[6:0], sda.lvl};
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (shift[6:0] == C_TARGET_ADDR) begin
                  state <= ST_ADDR_ACK;
                  rw    <= sda.lvl;
                  if (sda.lvl == I2C_RW_WRITE) begin
                    bus.rx_begin_o <= 1'b1;
                    rx_active      <= 1'b1;
                  end else begin
                    bus.tx_byte_req_o <= 1'b1;
                  end
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            // First fall starts the ACK; second fall ends it and, for reads, puts out bit 7.
            if (scl.fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw == I2C_RW_READ) begin
                sda_oe <= ~tx_shift[7];
                state  <= ST_READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            if (scl.rise) begin
              shift <= {shift[6:0], sda.lvl};
              if (bit_cnt == 4'd7) begin
                bit_cnt             <= 4'd0;
                bus.rx_byte_o       <= {shift[6:0], sda.lvl};
                bus.rx_byte_valid_o <= 1'b1;
                state               <= ST_WRITE_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_WRITE_ACK: begin
            if (scl.fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WRITE;
              end
            end
          end
          ST_READ: begin
            if (scl.rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl.fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_READ_ACK;
              end else begin
                sda_oe <= ~tx_shift[3'd7 - bit_cnt[2:0]];
              end
            end
          end
          ST_READ_ACK: begin
            if (scl.rise) begin
              if (!sda.lvl) begin
                bus.tx_byte_req_o <= 1'b1;
                state             <= ST_READ;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_IDLE, ST_IGNORE: begin
          end
          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign I2C_SDA_O  = 1'b0;
  assign I2C_SDA_OE = sda_oe;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level master driving i2c_target; transfers checked against a transaction-level model.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam logic [6:0] TGT = 7'h50;
  localparam int         Q   = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_o;
  logic sda_oe;
  logic sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_if bus ();

  i2c_target #(.C_TARGET_ADDR(TGT), .C_SYNC_STAGES(2), .C_FILTER_LEN(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .I2C_SCL_I  (scl_m),
    .I2C_SDA_I  (sda_line),
    .I2C_SDA_O  (sda_o),
    .I2C_SDA_OE (sda_oe),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: only this process writes the counters and tx_rd.
  int         n_begin = 0;
  int         n_end   = 0;
  int         n_req   = 0;
  int         n_oe    = 0;
  int         tx_rd   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  initial begin
    bus.tx_byte_i = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rx_begin_o)      n_begin++;
      if (bus.rx_end_o)        n_end++;
      if (bus.rx_byte_valid_o) rx_q.push_back(bus.rx_byte_o);
      if (sda_oe)              n_oe++;
      if (bus.tx_byte_req_o) begin
        n_req++;
        bus.tx_byte_i = (tx_rd < tx_q.size()) ? tx_q[tx_rd] : 8'hEE;
        tx_rd++;
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "tb_i2c_target timeout");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
    end
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    b = sda_line; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  logic [7:0] txd [0:3];

  // Reference: matched address ACKs every byte; writes reappear as rx frames,
  // reads return the queued bytes; any other address never touches SDA.
  task automatic do_txn(input logic [6:0] a, input logic rw, input int len, input string tag);
    logic       ack;
    logic [7:0] got;
    logic       hit;
    int b_beg, b_end, b_req, b_oe, b_rx;
    hit   = (a == TGT);
    b_beg = n_begin; b_end = n_end; b_req = n_req; b_oe = n_oe; b_rx = rx_q.size();
    if (hit && rw) for (int i = 0; i < len; i++) tx_q.push_back(txd[i]);
    i2c_start();
    check_val({tag, ":busy_start"}, 32'(bus.busy_o), 32'd1);
    write_byte({a, rw}, ack);
    check_val({tag, ":addr_ack"}, 32'(ack), 32'(!hit));
    for (int i = 0; i < len; i++) begin
      if (!rw) begin
        write_byte(txd[i], ack);
        check_val({tag, ":data_ack"}, 32'(ack), 32'(!hit));
      end else begin
        read_byte(got, (i == len - 1));
        check_val({tag, ":rd_data"}, 32'(got), hit ? 32'(txd[i]) : 32'hFF);
      end
    end
    check_val({tag, ":end_before_stop"}, 32'(n_end - b_end), 32'd0);
    i2c_stop();
    wq(8);
    check_val({tag, ":busy_stop"}, 32'(bus.busy_o), 32'd0);
    check_val({tag, ":n_begin"}, 32'(n_begin - b_beg), 32'(hit && !rw));
    check_val({tag, ":n_end"}, 32'(n_end - b_end), 32'(hit && !rw));
    check_val({tag, ":n_req"}, 32'(n_req - b_req), (hit && rw) ? 32'(len) : 32'd0);
    check_val({tag, ":n_rx"}, 32'(rx_q.size() - b_rx), (hit && !rw) ? 32'(len) : 32'd0);
    if (hit && !rw && (rx_q.size() - b_rx) == len)
      for (int i = 0; i < len; i++) check_val({tag, ":rx_byte"}, 32'(rx_q[b_rx + i]), 32'(txd[i]));
    if (!hit) check_val({tag, ":oe_never"}, 32'(n_oe - b_oe), 32'd0);
  endtask

  task automatic test_rep_start();
    logic       ack;
    logic [7:0] got;
    int b_beg, b_end, b_req, b_rx;
    b_beg = n_begin; b_end = n_end; b_req = n_req; b_rx = rx_q.size();
    tx_q.push_back(8'h9B);
    i2c_start();
    write_byte({TGT, I2C_RW_WRITE}, ack);
    check_val("rs:addr_w_ack", 32'(ack), 32'd0);
    write_byte(8'h77, ack);
    check_val("rs:data_ack", 32'(ack), 32'd0);
    check_val("rs:end_before_sr", 32'(n_end - b_end), 32'd0);
    i2c_start();
    check_val("rs:end_at_sr", 32'(n_end - b_end), 32'd1);
    check_val("rs:busy_sr", 32'(bus.busy_o), 32'd1);
    write_byte({TGT, I2C_RW_READ}, ack);
    check_val("rs:addr_r_ack", 32'(ack), 32'd0);
    read_byte(got, 1'b1);
    check_val("rs:rd_data", 32'(got), 32'h9B);
    i2c_stop();
    wq(8);
    check_val("rs:n_end", 32'(n_end - b_end), 32'd1);
    check_val("rs:n_begin", 32'(n_begin - b_beg), 32'd1);
    check_val("rs:n_req", 32'(n_req - b_req), 32'd1);
    check_val("rs:n_rx", 32'(rx_q.size() - b_rx), 32'd1);
    if (rx_q.size() > b_rx) check_val("rs:rx_byte", 32'(rx_q[b_rx]), 32'h77);
  endtask

  task automatic test_reset_mid();
    logic       ack;
    logic [7:0] ab;
    int b_end, b_rx;
    ab = {TGT, I2C_RW_WRITE};
    b_end = n_end; b_rx = rx_q.size();
    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(ab[i]);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(2);
    check_val("rst:oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1; wq(1);
    check_val("rst:oe_released", 32'(sda_oe), 32'd0);
    check_val("rst:busy_cleared", 32'(bus.busy_o), 32'd0);
    wq(1); rst = 1'b0;
    wq(Q); scl_m = 1'b0; wq(Q);
    i2c_stop(); wq(8);
    // Reset in the middle of a data bit.
    i2c_start();
    write_byte(ab, ack);
    check_val("rst:addr_ack2", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    rst = 1'b1; wq(1);
    check_val("rst:busy_mid_bit", 32'(bus.busy_o), 32'd0);
    check_val("rst:oe_mid_bit", 32'(sda_oe), 32'd0);
    rst = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
    for (int i = 0; i < 3; i++) write_bit(1'b1);
    read_bit(ack);
    check_val("rst:no_ack_after", 32'(ack), 32'd1);
    i2c_stop(); wq(8);
    check_val("rst:no_rx_end", 32'(n_end - b_end), 32'd0);
    check_val("rst:no_rx_byte", 32'(rx_q.size() - b_rx), 32'd0);
    check_val("rst:busy_end", 32'(bus.busy_o), 32'd0);
  endtask

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    sda_m = 1'b0; wq(1); sda_m = 1'b1; wq(20);
    check_val("glt:no_start", 32'(bus.busy_o), 32'd0);
    i2c_start();
    write_byte({7'h33, I2C_RW_WRITE}, ack);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(1); sda_m = 1'b0; wq(20);
    check_val("glt:no_stop", 32'(bus.busy_o), 32'd1);
    scl_m = 1'b0; wq(Q);
    i2c_stop(); wq(8);
    check_val("glt:real_stop", 32'(bus.busy_o), 32'd0);
  endtask
`endif

  initial begin
    logic [6:0] ra;
    logic       rrw;
    int         rlen;
    wq(8);
    check_val("reset:oe", 32'(sda_oe), 32'd0);
    check_val("reset:sda_o", 32'(sda_o), 32'd0);
    check_val("reset:busy", 32'(bus.busy_o), 32'd0);
    check_val("reset:rx_byte", 32'(bus.rx_byte_o), 32'd0);
    check_val("reset:pulses", 32'({bus.rx_begin_o, bus.rx_byte_valid_o, bus.rx_end_o, bus.tx_byte_req_o}), 32'd0);
    rst = 1'b0;
    wq(8);

    txd[0] = 8'h12; txd[1] = 8'h34;
    do_txn(TGT, I2C_RW_WRITE, 2, "wr2");
    txd[0] = 8'hFF;
    do_txn(7'h51, I2C_RW_WRITE, 1, "wrong_addr");
    txd[0] = 8'h5A; txd[1] = 8'hC3;
    do_txn(TGT, I2C_RW_READ, 2, "rd2");
    test_rep_start();
    test_reset_mid();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif

    for (int t = 0; t < 14; t++) begin
      ra   = ($urandom_range(0, 2) != 0) ? TGT : 7'($urandom_range(0, 127));
      rrw  = 1'($urandom_range(0, 1));
      rlen = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) txd[i] = 8'($urandom);
      do_txn(ra, rrw, rlen, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
